// File: rtl/led_fade_pwm_if.sv
// LED fade/PWM port bundle: PIO request side in, dimmed LED drive out.
// Master drives requests, slave is the fader.
interface led_fade_pwm_if #(
  parameter int N_LED = 18
);
  logic [N_LED-1:0] led_req;
  logic             fade_en;
  logic [N_LED-1:0] led_out;
  logic             busy;
  logic             pwm_sync;

  modport master (
    output led_req, fade_en,
    input  led_out, busy, pwm_sync
  );

  modport slave (
    input  led_req, fade_en,
    output led_out, busy, pwm_sync
  );
endinterface

// File: rtl/led_fade_pwm.sv
// Per-LED PWM dimmer with saturating fade ramps driven from PIO requests.
// Shared PWM counter and ramp prescaler for all channels.
module led_fade_pwm #(
  parameter int N_LED    = 18,
  parameter int PWM_BITS = 8,
  parameter int TICK_DIV = 50000,
  parameter int STEP     = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  led_fade_pwm_if.slave bus
);
  localparam int MAX_LVL = (1 << PWM_BITS) - 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST =
    PW'(TICK_DIV - 1);
  localparam logic [PWM_BITS-1:0] CNT_LAST =
    PWM_BITS'(MAX_LVL - 1);
  localparam logic [PWM_BITS-1:0] LVL_MAX =
    PWM_BITS'(MAX_LVL);
  localparam logic [PWM_BITS:0] MAX_W =
    (PWM_BITS+1)'(MAX_LVL);
  localparam logic [PWM_BITS:0] STEP_W =
    (PWM_BITS+1)'(STEP);

  logic [N_LED-1:0]    r_req_q;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PW-1:0]       r_presc;
  logic [PWM_BITS-1:0] r_level [N_LED];
  logic [N_LED-1:0]    r_led_out;
  logic                r_busy;
  logic                r_pwm_sync;

  logic                w_tick;
  logic [PWM_BITS-1:0] w_lvl_nxt [N_LED];
  logic [N_LED-1:0]    w_diff;
  logic [N_LED-1:0]    w_on;

  assign w_tick = (r_presc == PRESC_LAST);

  for (genvar g = 0; g < N_LED; g++) begin : g_ch
    logic [PWM_BITS-1:0] w_tgt;
    logic [PWM_BITS:0]   w_up;
    logic [PWM_BITS:0]   w_dn;
    logic [PWM_BITS-1:0] w_nxt;

    assign w_tgt = r_req_q[g] ? LVL_MAX : '0;
    // One guard bit so both directions saturate instead of wrapping
    assign w_up = {1'b0, r_level[g]} + STEP_W;
    assign w_dn = {1'b0, r_level[g]} - STEP_W;

    always_comb begin
      w_nxt = r_level[g];
      if (!bus.fade_en) begin
        w_nxt = w_tgt;
      end else if (w_tick) begin
        if (r_req_q[g]) begin
          w_nxt = (w_up > MAX_W) ? LVL_MAX
                                 : w_up[PWM_BITS-1:0];
        end else begin
          w_nxt = w_dn[PWM_BITS] ? '0
                                 : w_dn[PWM_BITS-1:0];
        end
      end
    end

    assign w_lvl_nxt[g] = w_nxt;
    assign w_diff[g]    = (r_level[g] != w_tgt);
    assign w_on[g]      = (r_level[g] > r_pwm_cnt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req_q    <= '0;
      r_pwm_cnt  <= '0;
      r_presc    <= '0;
      r_led_out  <= '0;
      r_busy     <= 1'b0;
      r_pwm_sync <= 1'b0;
      for (int i = 0; i < N_LED; i++) begin
        r_level[i] <= '0;
      end
    end else begin
      r_req_q    <= bus.led_req;
      r_pwm_cnt  <= (r_pwm_cnt == CNT_LAST) ? '0
                                            : r_pwm_cnt + 1'b1;
      r_presc    <= w_tick ? '0 : r_presc + 1'b1;
      r_led_out  <= w_on;
      r_busy     <= |w_diff;
      r_pwm_sync <= (r_pwm_cnt == '0);
      for (int i = 0; i < N_LED; i++) begin
        r_level[i] <= w_lvl_nxt[i];
      end
    end
  end

  assign bus.led_out  = r_led_out;
  assign bus.busy     = r_busy;
  assign bus.pwm_sync = r_pwm_sync;
endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench for led_fade_pwm: reset, snap, ramps, reversal, duty.
// A second slow-tick instance is used to measure PWM duty per level.
module tb_led_fade_pwm;
  localparam int N = 18;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  led_fade_pwm_if #(.N_LED(N)) bus ();
  led_fade_pwm_if #(.N_LED(N)) sbus ();

  led_fade_pwm #(
    .N_LED(N), .PWM_BITS(8), .TICK_DIV(4), .STEP(64)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  led_fade_pwm #(
    .N_LED(N), .PWM_BITS(8), .TICK_DIV(1024), .STEP(64)
  ) u_slow (
    .clk(clk), .reset_n(reset_n), .bus(sbus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic next_level(input string tag, input int exp);
    logic [7:0] prev;
    int n;
    prev = dut.r_level[0];
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dut.r_level[0] == prev && n < 40);
    chk(tag, 32'(dut.r_level[0]), exp);
  endtask

  task automatic clear_fast();
    bus.fade_en = 1'b0;
    bus.led_req = '0;
    cyc(5);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int bad, pulses, last, badint, hi, n;
    logic [7:0] prev;
    int duty [4];
    duty[0] = 64; duty[1] = 128;
    duty[2] = 192; duty[3] = 255;

    bus.led_req  = '0;
    bus.fade_en  = 1'b1;
    sbus.led_req = '0;
    sbus.fade_en = 1'b1;
    reset_n = 1'b0;
    cyc(3);
    chk("rst_out", 32'(bus.led_out), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_sync", 32'(bus.pwm_sync), 0);
    reset_n = 1'b1;

    // quiet outputs and pwm_sync spacing
    bad = 0; pulses = 0; last = -1; badint = 0;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      if (bus.led_out != '0 || bus.busy) bad++;
      if (bus.pwm_sync) begin
        if (last >= 0 && i - last != 255) badint++;
        last = i;
        pulses++;
      end
    end
    chk("t1_quiet", 32'(bad), 0);
    chk("t1_sync_n", 32'(pulses), 4);
    chk("t1_sync_gap", 32'(badint), 0);

    // snap with fade disabled
    bus.fade_en = 1'b0;
    bus.led_req = '1;
    @(negedge clk);
    chk("t2_lvl_n1", 32'(dut.r_level[0]), 0);
    chk("t2_busy_n1", 32'(bus.busy), 0);
    @(negedge clk);
    chk("t2_lvl0", 32'(dut.r_level[0]), 255);
    chk("t2_lvl17", 32'(dut.r_level[17]), 255);
    chk("t2_busy", 32'(bus.busy), 1);
    chk("t2_out_n2", 32'(bus.led_out), 0);
    @(negedge clk);
    chk("t2_out", 32'(bus.led_out), 32'h3FFFF);
    chk("t2_busy_off", 32'(bus.busy), 0);
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.led_out != '1 || bus.busy) bad++;
    end
    chk("t2_hold", 32'(bad), 0);

    // ramp up, saturating
    clear_fast();
    chk("t3_clr_busy", 32'(bus.busy), 0);
    bus.fade_en = 1'b1;
    bus.led_req = 18'h1;
    next_level("t3_s1", 64);
    next_level("t3_s2", 128);
    next_level("t3_s3", 192);
    next_level("t3_s4", 255);
    chk("t3_busy_at", 32'(bus.busy), 1);
    @(negedge clk);
    chk("t3_busy_off", 32'(bus.busy), 0);

    // reversal at 128
    clear_fast();
    bus.fade_en = 1'b1;
    bus.led_req = 18'h1;
    next_level("t4_u1", 64);
    next_level("t4_u2", 128);
    bus.led_req = '0;
    next_level("t4_d1", 64);
    next_level("t4_d2", 0);
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.led_out[0] || dut.r_level[0] != 0) bad++;
    end
    chk("t4_stay0", 32'(bad), 0);
    chk("t4_busy", 32'(bus.busy), 0);

    // async reset mid-ramp
    clear_fast();
    bus.fade_en = 1'b1;
    bus.led_req = '1;
    next_level("t5_pre", 64);
    chk("t5_busy_pre", 32'(bus.busy), 1);
    reset_n = 1'b0;
    #1;
    chk("t5_busy_async", 32'(bus.busy), 0);
    chk("t5_out_async", 32'(bus.led_out), 0);
    chk("t5_lvl_async", 32'(dut.r_level[0]), 0);
    cyc(3);
    reset_n = 1'b1;
    next_level("t5_r1", 64);
    next_level("t5_r2", 128);

    // fade_en 1->0 snap, then 0->1 ramp down
    clear_fast();
    bus.fade_en = 1'b1;
    bus.led_req = 18'h1;
    next_level("t6_pre", 64);
    bus.fade_en = 1'b0;
    @(negedge clk);
    chk("t6_snap", 32'(dut.r_level[0]), 255);
    bus.fade_en = 1'b1;
    bus.led_req = '0;
    next_level("t6_d1", 191);
    next_level("t6_d2", 127);
    next_level("t6_d3", 63);
    next_level("t6_d4", 0);

    // measured duty per level on the slow instance
    sbus.led_req = 18'h1;
    for (int k = 0; k < 4; k++) begin
      prev = u_slow.r_level[0];
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (u_slow.r_level[0] == prev && n < 2100);
      chk($sformatf("t3_slow_lvl%0d", k),
          32'(u_slow.r_level[0]), duty[k]);
      n = 0;
      while (!sbus.pwm_sync && n < 300) begin
        @(negedge clk);
        n++;
      end
      hi = 0;
      for (int j = 0; j < 255; j++) begin
        if (j > 0) @(negedge clk);
        if (sbus.led_out[0]) hi++;
      end
      chk($sformatf("t3_duty%0d", k), 32'(hi), duty[k]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/led_fade_pwm.md
Name: led_fade_pwm

Overview:
- Downstream consumer of the 18-bit LED output PIO's out_port.
- Turns each on/off request bit into a PWM-dimmed LED drive. Each channel fades up or down at a fixed rate instead of switching instantly.
- Sits between the PIO and the board LED pins. Same clock domain as the Avalon fabric.

Parameters:
- N_LED, 18, number of LED channels (matches PIO width).
- PWM_BITS, 8, brightness resolution. MAX_LVL = 2^PWM_BITS-1.
- TICK_DIV, 50000, clk cycles per ramp step. Must be >=1.
- STEP, 4, level increment/decrement per ramp tick. Range 1..MAX_LVL.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset.
- led_req  input  N_LED  per-LED on request, driven by PIO out_port.
- fade_en  input  1  1 = ramp levels; 0 = snap levels to target.
- led_out  output  N_LED  PWM-modulated LED drive, registered.
- busy  output  1  high while any channel level differs from its target.
- pwm_sync  output  1  one-cycle pulse at the start of each PWM period.

Behaviour:
- Clocking and reset: clk, rising edge. reset_n is asynchronous, active-low.
- Reset values:
  - pwm_cnt=0, presc=0, all level[i]=0, req_q=0.
  - led_out=0, busy=0, pwm_sync=0.
  - Reset asserted mid-operation clears everything immediately. Ramps restart from 0 after release.
- Input register: req_q <= led_req every cycle. target[i] = req_q[i] ? MAX_LVL : 0.
- PWM counter:
  - pwm_cnt counts 0..MAX_LVL-1, then wraps to 0.
  - Period is MAX_LVL cycles (255 at default).
  - pwm_sync is a registered pulse, high the cycle after pwm_cnt==0.
- Prescaler and tick:
  - presc counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 in the cycle presc==TICK_DIV-1. TICK_DIV=1 gives a tick every cycle.
  - The prescaler free-runs regardless of fade_en.
- Level update, fade_en=1, only on tick, per channel:
  - req_q=1, level<MAX_LVL: level <= min(level+STEP, MAX_LVL).
  - req_q=0, level>0: level <= max(level-STEP, 0).
  - Arithmetic uses PWM_BITS+1 bits, then saturates. No wrap-around is ever allowed.
  - Direction is re-evaluated every tick, so a reversal mid-ramp takes effect at the next tick from the current level.
- Level update, fade_en=0: every cycle, level <= target. fade_en 1->0 mid-ramp snaps on the next clock.
- fade_en 0->1: ramps continue from the current levels.
- Output:
  - led_out[i] <= (level[i] > pwm_cnt). Registered, 1 cycle.
  - level 0 means always off. level MAX_LVL means always on, with no glitch at wrap.
- Latency, fade_en=0: led_req change at edge n -> req_q at n+1 -> level at n+2 -> led_out settled from n+3.
- busy:
  - Registered. busy <= OR over i of (level[i] != target[i]).
  - Falls on the cycle after the last channel reaches its target.
- Simultaneous events:
  - A led_req change in a tick cycle is not seen by that tick, because req_q lags by 1.
  - A tick coinciding with pwm_cnt wrap needs no special handling.

Test Plan:
Bench parameters: PWM_BITS=8, TICK_DIV=4, STEP=64.
1. Reset then release, led_req=0, fade_en=1:
   - led_out=0 and busy=0 for 1000 cycles.
   - pwm_sync pulses every 255 cycles.
2. fade_en=0, led_req 0 -> 0x3FFFF at edge n:
   - level=255 for all channels at n+2.
   - led_out=0x3FFFF continuously from n+3.
   - busy high only at n+2.
3. fade_en=1, led_req bit0 rises:
   - level0 steps 64,128,192,255 on successive ticks (saturates, no overflow).
   - Measured led_out[0] high count per period is 64,128,192,255.
   - busy drops 1 cycle after level0=255.
4. Reversal at level0=128 (led_req[0] -> 0):
   - Next ticks give 64, then 0, never negative.
   - led_out[0] stays 0 once level=0.
   - busy clears.
5. Ramp in progress, reset_n pulsed low for 3 cycles:
   - led_out=0 and busy=0 asynchronously.
   - After release with led_req=1, ramp restarts 64,128,...
6. fade_en toggles 1->0 with level=64 and led_req=1:
   - level=255 next cycle.
   - Toggle back to 1 with led_req=0: level ramps 191,127,63,0.
